pipe_flush_ctrl: RTL and testbench

Stage-valid tracker and redirect sequencer that consumes the hazard unit's flush outputs (`IF_IDFLUSH`, `ID_EXFLUSH`, `EX_MAFLUSH`). It keeps one valid bit per pipeline latch (ID, EX, MA, WB), kills the stages it is told to flush, and inserts bubbles on load-use stalls. After a flush it issues a registered PC redirect to fetch, then runs a refill sequence and keeps a saturating squash counter for performance analysis.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_flush_ctrl.sv | 93 +++++++++
 tb/tb_pipe_flush_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM states, stage indices and default widths for the flush controller
package pipe_pkg;
    typedef enum logic [1:0] {RUN, REDIRECT, REFILL} state_e;
    localparam logic [1:0] STG_ID = 2'd0;
    localparam logic [1:0] STG_EX = 2'd1;
    localparam logic [1:0] STG_MA = 2'd2;
    localparam logic [1:0] STG_WB = 2'd3;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_REFILL_CYC = 3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter that adds 0..3 per cycle and clamps at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic [W+1:0] sum;
    // two guard bits so even a 1-bit counter cannot wrap the sum
    always_comb begin
        sum = {2'b00, cnt_q} + {{W{1'b0}}, inc_i};
        cnt_d = (|sum[W+1:W]) ? '1 : sum[W-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: stage-valid tracking, flush/stall handling, PC redirect and refill sequencing
module pipe_flush_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int REFILL_CYC = DEF_REFILL_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IF_IDFLUSH,
    input  logic              ID_EXFLUSH,
    input  logic              EX_MAFLUSH,
    input  logic              STALL,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              v_id,
    output logic              v_ex,
    output logic              v_ma,
    output logic              v_wb,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              refill_busy,
    output logic [CNT_W-1:0]  squash_count
);
    localparam int RW = $clog2(REFILL_CYC + 1);
    logic any_flush, hold;
    logic [3:0] v_q, v_d;
    logic [1:0] inc;
    state_e state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    assign any_flush = IF_IDFLUSH | ID_EXFLUSH | EX_MAFLUSH;
    // a stall is moot when a flush squashes the stalled (younger) instruction anyway
    assign hold = STALL & ~any_flush;
    always_comb begin
        v_d = v_q;
        v_d[STG_WB] = v_q[STG_MA];
        v_d[STG_MA] = EX_MAFLUSH ? 1'b0 : v_q[STG_EX];
        v_d[STG_EX] = (ID_EXFLUSH | hold) ? 1'b0 : v_q[STG_ID];
        v_d[STG_ID] = IF_IDFLUSH ? 1'b0 : hold ? v_q[STG_ID] : fetch_valid;
    end
    assign inc = {1'b0, fetch_valid & IF_IDFLUSH} + {1'b0, v_q[STG_ID] & ID_EXFLUSH}
               + {1'b0, v_q[STG_EX] & EX_MAFLUSH};
    always_comb begin
        state_d = state_q;
        rcnt_d = rcnt_q;
        rpc_d = rpc_q;
        case (state_q)
            RUN: state_d = RUN;
            REDIRECT: begin
                state_d = REFILL;
                rcnt_d = RW'(REFILL_CYC - 1);
            end
            REFILL: begin
                state_d = (rcnt_q == '0) ? RUN : REFILL;
                rcnt_d = (rcnt_q == '0) ? '0 : rcnt_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
        // the newest flush always wins and restarts the sequence
        if (any_flush) begin
            state_d = REDIRECT;
            rpc_d = branch_target;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            state_q <= RUN;
            rcnt_q <= '0;
            rpc_q <= '0;
        end else begin
            v_q <= v_d;
            state_q <= state_d;
            rcnt_q <= rcnt_d;
            rpc_q <= rpc_d;
        end
    end
    sat_counter #(.W(CNT_W)) u_sq (
        .clk  (clk),
        .rst  (rst),
        .inc_i(inc),
        .cnt_o(squash_count)
    );
    assign v_id = v_q[STG_ID];
    assign v_ex = v_q[STG_EX];
    assign v_ma = v_q[STG_MA];
    assign v_wb = v_q[STG_WB];
    assign redirect_valid = state_q == REDIRECT;
    assign refill_busy = state_q == REFILL;
    assign redirect_pc = rpc_q;
endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// tb_pipe_flush_ctrl: directed vectors with hand-computed expectations checked by a queue-driven monitor
module tb_pipe_flush_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ifid = 1'b0, idex = 1'b0, exma = 1'b0, stall = 1'b0, fv = 1'b0;
    logic [15:0] tgt = '0;
    logic v_id, v_ex, v_ma, v_wb, rv, rb;
    logic [15:0] rpc, sq;
    logic v_id2, v_ex2, v_ma2, v_wb2, rv2, rb2;
    logic [15:0] rpc2;
    logic [1:0] sq2;
    int total = 0, bad = 0, vec_n = 0;
    typedef struct packed {
        logic [3:0] v;
        logic rv;
        logic [15:0] rpc;
        logic rb;
        logic [15:0] sq;
        logic [1:0] sq2;
    } exp_t;
    exp_t q[$];
    always #5 clk = ~clk;
    pipe_flush_ctrl dut (
        .clk(clk), .rst(rst), .IF_IDFLUSH(ifid), .ID_EXFLUSH(idex), .EX_MAFLUSH(exma),
        .STALL(stall), .fetch_valid(fv), .branch_target(tgt),
        .v_id(v_id), .v_ex(v_ex), .v_ma(v_ma), .v_wb(v_wb),
        .redirect_valid(rv), .redirect_pc(rpc), .refill_busy(rb), .squash_count(sq)
    );
    pipe_flush_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .IF_IDFLUSH(ifid), .ID_EXFLUSH(idex), .EX_MAFLUSH(exma),
        .STALL(stall), .fetch_valid(fv), .branch_target(tgt),
        .v_id(v_id2), .v_ex(v_ex2), .v_ma(v_ma2), .v_wb(v_wb2),
        .redirect_valid(rv2), .redirect_pc(rpc2), .refill_busy(rb2), .squash_count(sq2)
    );
    task automatic chk(input int n, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", n, name, act, exp);
        end
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(vec_n, "valid{wb,ma,ex,id}", {28'd0, v_wb, v_ma, v_ex, v_id}, {28'd0, e.v});
            chk(vec_n, "redirect_valid", {31'd0, rv}, {31'd0, e.rv});
            chk(vec_n, "redirect_pc", {16'd0, rpc}, {16'd0, e.rpc});
            chk(vec_n, "refill_busy", {31'd0, rb}, {31'd0, e.rb});
            chk(vec_n, "squash_count", {16'd0, sq}, {16'd0, e.sq});
            chk(vec_n, "squash_count_w2", {30'd0, sq2}, {30'd0, e.sq2});
            vec_n++;
        end
    end
    task automatic vec(input logic r, input logic a, input logic b, input logic c,
                       input logic s, input logic f, input logic [15:0] t,
                       input logic [3:0] ev, input logic erv, input logic [15:0] erpc,
                       input logic erb, input logic [15:0] esq, input logic [1:0] esq2);
        @(negedge clk);
        rst = r; ifid = a; idex = b; exma = c; stall = s; fv = f; tgt = t;
        q.push_back('{v: ev, rv: erv, rpc: erpc, rb: erb, sq: esq, sq2: esq2});
    endtask
    initial begin
        //  rst if id ex st fv tgt        wb/ma/ex/id rv rpc   rb sq  sq2
        vec(1, 0, 0, 0, 0, 0, 16'h0000,  4'b0000, 0, 16'h0000, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b0001, 0, 16'h0000, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b0011, 0, 16'h0000, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b0111, 0, 16'h0000, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b1111, 0, 16'h0000, 0, 0, 0);
        vec(0, 1, 1, 0, 0, 1, 16'h0040,  4'b1100, 1, 16'h0040, 0, 2, 2);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b1001, 0, 16'h0040, 1, 2, 2);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b0011, 0, 16'h0040, 1, 2, 2);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b0111, 0, 16'h0040, 1, 2, 2);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b1111, 0, 16'h0040, 0, 2, 2);
        vec(0, 1, 1, 1, 1, 1, 16'h0100,  4'b1000, 1, 16'h0100, 0, 5, 3);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b0001, 0, 16'h0100, 1, 5, 3);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b0011, 0, 16'h0100, 1, 5, 3);
        vec(0, 0, 0, 0, 1, 1, 16'h0000,  4'b0101, 0, 16'h0100, 1, 5, 3);
        vec(0, 0, 0, 0, 1, 0, 16'h0000,  4'b1001, 0, 16'h0100, 0, 5, 3);
        vec(0, 0, 0, 0, 0, 0, 16'h0000,  4'b0010, 0, 16'h0100, 0, 5, 3);
        vec(0, 1, 0, 0, 0, 1, 16'h0200,  4'b0100, 1, 16'h0200, 0, 6, 3);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b1001, 0, 16'h0200, 1, 6, 3);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b0011, 0, 16'h0200, 1, 6, 3);
        vec(0, 1, 0, 0, 0, 1, 16'h0080,  4'b0110, 1, 16'h0080, 0, 7, 3);
        vec(0, 0, 0, 0, 0, 0, 16'h0000,  4'b1100, 0, 16'h0080, 1, 7, 3);
        vec(0, 0, 0, 0, 0, 0, 16'h0000,  4'b1000, 0, 16'h0080, 1, 7, 3);
        vec(0, 0, 0, 0, 0, 0, 16'h0000,  4'b0000, 0, 16'h0080, 1, 7, 3);
        vec(0, 0, 0, 0, 0, 0, 16'h0000,  4'b0000, 0, 16'h0080, 0, 7, 3);
        vec(0, 1, 0, 0, 0, 1, 16'h0300,  4'b0000, 1, 16'h0300, 0, 8, 3);
        vec(0, 1, 0, 0, 0, 1, 16'h0304,  4'b0000, 1, 16'h0304, 0, 9, 3);
        vec(0, 0, 0, 0, 0, 1, 16'h0000,  4'b0001, 0, 16'h0304, 1, 9, 3);
        vec(1, 0, 0, 0, 0, 1, 16'h0000,  4'b0000, 0, 16'h0000, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 16'h0000,  4'b0000, 0, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
